// File: rtl/arb_mux_rr_if.sv
// Bundle of per-channel input handshakes plus the single registered output port.
// Latency: none, wiring only.
// Backpressure: carries in_ready towards producers and out_ready from the consumer.
interface arb_mux_rr_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    localparam int CH_W = (NCH > 2) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CH_W-1:0]      out_ch;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    // Arbiter side: consumes channel beats, drives the output register.
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_ch, out_last, out_valid
    );

    // Environment side: producers and the downstream consumer.
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_ch, out_last, out_valid
    );
endinterface

// File: rtl/arb_mux_rr.sv
// N:1 arbitrating mux, round-robin or fixed priority, grant locked across multi-beat transfers.
// Latency: 1 cycle from accepted input beat to out_valid; 1 beat/cycle under continuous out_ready.
// Backpressure: in_ready is all-zero while the output register holds a beat and out_ready is low.
module arb_mux_rr #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int MODE_RR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    arb_mux_rr_if.slave bus
);
    localparam int CH_W = (NCH > 2) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]  r_out_ch;
    logic             r_out_last;
    logic             r_out_valid;
    logic [CH_W-1:0]  r_ptr;
    logic             r_lock;
    logic [CH_W-1:0]  r_lock_ch;

    logic             w_load_en;
    logic [NCH-1:0]   w_elig;
    logic [CH_W-1:0]  w_start;
    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;
    logic [CH_W:0]    w_sum;
    logic             w_any;
    logic [CH_W-1:0]  w_gnt;
    logic [NCH-1:0]   w_gnt_oh;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_accept;
    logic [CH_W-1:0]  w_ptr_nxt;

    // The output register can take a beat when empty or being drained this cycle.
    assign w_load_en = !r_out_valid || bus.out_ready;

    // While a transfer is open only its owner may be considered; others wait.
    always_comb begin
        w_elig = bus.in_valid;
        if (r_lock) begin
            w_elig = '0;
            for (int c = 0; c < NCH; c++) begin
                if (CH_W'(c) == r_lock_ch) w_elig[c] = bus.in_valid[c];
            end
        end
    end

    // Rotate the eligibility vector so the search always starts at bit 0, then map back.
    always_comb begin
        w_start  = (MODE_RR != 0) ? r_ptr : '0;
        w_dbl    = {w_elig, w_elig};
        w_rot    = NCH'(w_dbl >> w_start);
        w_any    = 1'b0;
        w_gnt    = '0;
        w_sum    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, w_start} + (CH_W+1)'(k);
                if (w_sum >= (CH_W+1)'(NCH)) w_sum = w_sum - (CH_W+1)'(NCH);
                w_gnt = w_sum[CH_W-1:0];
            end
        end
    end

    // One-hot grant and the data/last of the granted channel.
    always_comb begin
        w_gnt_oh   = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (w_any && (w_gnt == CH_W'(c))) begin
                w_gnt_oh[c] = 1'b1;
                w_sel_data  = bus.in_data[c*WIDTH +: WIDTH];
                w_sel_last  = bus.in_last[c];
            end
        end
    end

    // Eligible implies valid, so a granted ready is always an accept.
    assign w_accept     = rst_n && w_load_en && w_any;
    assign bus.in_ready = w_accept ? w_gnt_oh : '0;

    assign w_ptr_nxt = (w_gnt == CH_W'(NCH-1)) ? '0 : (w_gnt + 1'b1);

    // Output register: load on accept, clear valid on drain without refill, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt;
            r_out_last  <= w_sel_last;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Transfer lock and round-robin pointer; the pointer moves only at transfer end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_lock    <= !w_sel_last;
            r_lock_ch <= w_gnt;
            if (w_sel_last && (MODE_RR != 0)) r_ptr <= w_ptr_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_arb_mux_rr.sv
module tb_arb_mux_rr;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arb_mux_rr_if #(.WIDTH(16), .NCH(4)) bus4 ();
    arb_mux_rr_if #(.WIDTH(16), .NCH(3)) bus3f ();
    arb_mux_rr_if #(.WIDTH(16), .NCH(3)) bus3r ();

    arb_mux_rr #(.WIDTH(16), .NCH(4), .MODE_RR(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    arb_mux_rr #(.WIDTH(16), .NCH(3), .MODE_RR(0)) u3f (.clk(clk), .rst_n(rst_n), .bus(bus3f.slave));
    arb_mux_rr #(.WIDTH(16), .NCH(3), .MODE_RR(1)) u3r (.clk(clk), .rst_n(rst_n), .bus(bus3r.slave));

    // Uniform per-DUT views: index 0 = 4ch RR, 1 = 3ch fixed, 2 = 3ch RR.
    logic [3:0]  vld [3];
    logic [3:0]  lst [3];
    logic [63:0] dat [3];
    logic        ordy[3];
    logic [3:0]  rdy [3];
    logic        ov  [3];
    logic [15:0] od  [3];
    logic [1:0]  och [3];
    logic        olst[3];

    assign bus4.in_valid  = vld[0];
    assign bus4.in_last   = lst[0];
    assign bus4.in_data   = dat[0];
    assign bus4.out_ready = ordy[0];
    assign rdy[0] = bus4.in_ready;
    assign ov[0]  = bus4.out_valid;
    assign od[0]  = bus4.out_data;
    assign och[0] = bus4.out_ch;
    assign olst[0] = bus4.out_last;

    assign bus3f.in_valid  = vld[1][2:0];
    assign bus3f.in_last   = lst[1][2:0];
    assign bus3f.in_data   = dat[1][47:0];
    assign bus3f.out_ready = ordy[1];
    assign rdy[1] = {1'b0, bus3f.in_ready};
    assign ov[1]  = bus3f.out_valid;
    assign od[1]  = bus3f.out_data;
    assign och[1] = bus3f.out_ch;
    assign olst[1] = bus3f.out_last;

    assign bus3r.in_valid  = vld[2][2:0];
    assign bus3r.in_last   = lst[2][2:0];
    assign bus3r.in_data   = dat[2][47:0];
    assign bus3r.out_ready = ordy[2];
    assign rdy[2] = {1'b0, bus3r.in_ready};
    assign ov[2]  = bus3r.out_valid;
    assign od[2]  = bus3r.out_data;
    assign och[2] = bus3r.out_ch;
    assign olst[2] = bus3r.out_last;

    int nerr = 0;
    int nchk = 0;

    // Reference model: transfer-level state described in plain integers.
    int          nch [3] = '{4, 3, 3};
    int          mode[3] = '{1, 0, 1};
    int          m_ptr [3];
    int          m_lock[3];
    int          m_lch [3];
    int          m_ov  [3];
    logic [15:0] m_od  [3];
    int          m_och [3];
    logic        m_olst[3];
    logic [3:0]  seen_rdy[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_ptr[d] = 0; m_lock[d] = 0; m_lch[d] = 0;
            m_ov[d] = 0; m_od[d] = '0; m_och[d] = 0; m_olst[d] = 1'b0;
        end
    endtask

    // Which channel the rules grant this cycle, or -1.
    function automatic int exp_grant(input int d);
        int start;
        if (m_ov[d] != 0 && !ordy[d]) return -1;
        if (m_lock[d] != 0) return vld[d][m_lch[d]] ? m_lch[d] : -1;
        start = (mode[d] != 0) ? m_ptr[d] : 0;
        for (int k = 0; k < nch[d]; k++) begin
            if (vld[d][(start + k) % nch[d]]) return (start + k) % nch[d];
        end
        return -1;
    endfunction

    // One clock: inputs already set; check in_ready mid-cycle, outputs after the edge.
    task automatic tick();
        int g;
        logic [3:0] oh;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            g  = exp_grant(d);
            oh = (g < 0) ? 4'd0 : (4'd1 << g);
            seen_rdy[d] = rdy[d];
            check($sformatf("in_ready[dut%0d]", d), {28'd0, rdy[d]}, {28'd0, oh});
            if (g >= 0) begin
                m_ov[d]   = 1;
                m_od[d]   = dat[d][g*16 +: 16];
                m_och[d]  = g;
                m_olst[d] = lst[d][g];
                m_lock[d] = lst[d][g] ? 0 : 1;
                m_lch[d]  = g;
                if (lst[d][g] && mode[d] != 0) m_ptr[d] = (g + 1) % nch[d];
            end else if (m_ov[d] != 0 && ordy[d]) begin
                m_ov[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("out_valid[dut%0d]", d), {31'd0, ov[d]}, m_ov[d]);
            if (m_ov[d] != 0)
                check($sformatf("out_beat[dut%0d]", d), {13'd0, och[d], olst[d], od[d]},
                      {13'd0, 2'(m_och[d]), m_olst[d], m_od[d]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s out_valid[dut%0d]", tag, d), {31'd0, ov[d]}, 32'd0);
            check($sformatf("%s out_data/ch/last[dut%0d]", tag, d), {13'd0, och[d], olst[d], od[d]}, 32'd0);
            check($sformatf("%s in_ready[dut%0d]", tag, d), {28'd0, rdy[d]}, 32'd0);
        end
    endtask

    typedef struct packed {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // Directed sequence on the 4-channel RR instance, one row per cycle.
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[5]  = '{4'h5, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[6]  = '{4'h7, 4'hB, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[7]  = '{4'h7, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[8]  = '{4'h3, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[9]  = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0};
        tbl[10] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0};
        tbl[11] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0};
        tbl[12] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[13] = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[14] = '{4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[15] = '{4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1};
        tbl[16] = '{4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1};
        tbl[17] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[18] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1};

        for (int d = 0; d < 3; d++) begin
            vld[d] = 4'hF; lst[d] = 4'hF; ordy[d] = 1'b1;
            dat[d] = 64'h4444_3333_2222_1111;
        end
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        for (int d = 0; d < 3; d++) vld[d] = 4'h0;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            vld[0] = tbl[i].vld; lst[0] = tbl[i].lst; ordy[0] = tbl[i].ordy;
            tick();
            check($sformatf("tbl%0d in_ready", i), {28'd0, seen_rdy[0]}, {28'd0, tbl[i].rdy});
            check($sformatf("tbl%0d out_valid", i), {31'd0, ov[0]}, {31'd0, tbl[i].ov});
            if (tbl[i].ov)
                check($sformatf("tbl%0d out_ch/data", i), {14'd0, och[0], od[0]},
                      {14'd0, tbl[i].ch, 16'h1111 * (16'(tbl[i].ch) + 16'd1)});
        end

        // Channel 1 opens a 4-beat transfer; reset hits after the second beat.
        vld[0] = 4'h2; lst[0] = 4'h0;
        tick();
        tick();
        check("midlock beat2 ch", {30'd0, och[0]}, 32'd1);
        vld[1] = 4'h7; vld[2] = 4'h7;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midlock reset");
        model_reset();
        for (int d = 0; d < 3; d++) vld[d] = 4'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        vld[0] = 4'h3; lst[0] = 4'h3;
        tick();
        check("after reset first grant", {29'd0, ov[0], och[0]}, {29'd0, 1'b1, 2'd0});
        vld[0] = 4'h0;

        // Fixed priority starves channel 2; 3-channel RR wraps 2 -> 0.
        vld[1] = 4'h6; lst[1] = 4'hF;
        vld[2] = 4'h7; lst[2] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("fixed grant %0d", i), {28'd0, seen_rdy[1]}, 32'h2);
            check($sformatf("fixed out_ch %0d", i), {30'd0, och[1]}, 32'd1);
            check($sformatf("rr3 out_ch %0d", i), {30'd0, och[2]}, i % 3);
        end

        // Random traffic on all three instances against the model.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d]  = 4'($urandom);
                lst[d]  = 4'($urandom | $urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
                dat[d]  = {$urandom, $urandom};
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
